// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern and a repeat count on start, then shifts one bit per clk.
// Optional macro SEQ_TX_GAP_EN inserts one idle GAP cycle between repetitions.
module seq_pattern_tx #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             msb_first,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SEQ_TX_GAP_EN
    GAP   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic             x_reg;
  logic             x_valid_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [PAT_W-1:0] pattern_rev;
  logic [PAT_W-1:0] pattern_ord;

  // pat_reg is stored in transmit order so bit k of a repetition is always pat_reg[k].
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_rev
      assign pattern_rev[gi] = pattern[PAT_W-1-gi];
    end
  endgenerate

  assign pattern_ord = msb_first ? pattern_rev : pattern;
  assign idx_next    = idx_reg + IDX_W'(1);

  assign x       = x_reg;
  assign x_valid = x_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pat_reg     <= '0;
      rem_reg     <= '0;
      idx_reg     <= '0;
      x_reg       <= IDLE_BIT;
      x_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            pat_reg <= pattern_ord;
            rem_reg <= repeat_cnt;
            idx_reg <= '0;
            if (repeat_cnt != '0) begin
              state_reg   <= SHIFT;
              x_reg       <= pattern_ord[0];
              x_valid_reg <= 1'b1;
              busy_reg    <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (abort) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            idx_reg     <= '0;
            x_reg       <= IDLE_BIT;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (idx_reg == LAST_IDX) begin
            // rem_reg is at least 1 here, so the decrement cannot wrap.
            rem_reg <= rem_reg - CNT_W'(1);
            idx_reg <= '0;
            if (rem_reg > CNT_W'(1)) begin
`ifdef SEQ_TX_GAP_EN
              state_reg   <= GAP;
              x_reg       <= IDLE_BIT;
              x_valid_reg <= 1'b0;
`else
              state_reg   <= SHIFT;
              x_reg       <= pat_reg[0];
`endif
            end else begin
              state_reg   <= DONE;
              x_reg       <= IDLE_BIT;
              x_valid_reg <= 1'b0;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
            end
          end else begin
            idx_reg <= idx_next;
            x_reg   <= pat_reg[idx_next];
          end
        end

`ifdef SEQ_TX_GAP_EN
        GAP: begin
          if (abort) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            idx_reg     <= '0;
            x_reg       <= IDLE_BIT;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else begin
            state_reg   <= SHIFT;
            idx_reg     <= '0;
            x_reg       <= pat_reg[0];
            x_valid_reg <= 1'b1;
          end
        end
`endif

        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg   <= IDLE;
          x_reg       <= IDLE_BIT;
          x_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: offset-based reference model compared every cycle, plus literal stream checks.
// Honours SEQ_TX_GAP_EN when the design is built with it.
module tb_seq_pattern_tx;

  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SEQ_TX_GAP_EN
  localparam int   GAP = 1;
`else
  localparam int   GAP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             msb_first = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .IDLE_BIT(IDLE_BIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .msb_first  (msb_first),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transfer is an offset k from its start edge; everything follows from k.
  logic             m_active = 1'b0;
  int               m_k = 0;
  int               m_total = 0;
  logic [PAT_W-1:0] m_bits = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_total  <= (repeat_cnt == '0) ? 0 :
                    PAT_W * int'(repeat_cnt) + GAP * (int'(repeat_cnt) - 1);
        for (int i = 0; i < PAT_W; i++)
          m_bits[i] <= msb_first ? pattern[PAT_W-1-i] : pattern[i];
      end
    end else if (m_k == m_total) begin
      m_active <= 1'b0;
    end else if (abort) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Field order: 3=x, 2=x_valid, 1=busy, 0=done
  function automatic logic exp_field(input int f);
    logic [3:0] e;
    int pos;
    e = {IDLE_BIT, 3'b000};
    if (m_active) begin
      if (m_k == m_total) begin
        e[0] = 1'b1;
      end else begin
        e[1] = 1'b1;
        pos  = m_k % (PAT_W + GAP);
        if (pos < PAT_W) begin
          e[2] = 1'b1;
          e[3] = m_bits[pos];
        end
      end
    end
    return e[f];
  endfunction

  always @(negedge clk) begin
    check("model_x",       x,       exp_field(3));
    check("model_x_valid", x_valid, exp_field(2));
    check("model_busy",    busy,    exp_field(1));
    check("model_done",    done,    exp_field(0));
  end

  // Called at a negedge; returns at the negedge that observes the start edge N.
  task automatic begin_xfer(input logic [PAT_W-1:0] p, input int r, input logic m);
    pattern    = p;
    repeat_cnt = r[CNT_W-1:0];
    msb_first  = m;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Records n cycles of x/x_valid (first sample in the MSB), ending on the cycle after them.
  task automatic collect(input int n, output logic [15:0] xs, output logic [15:0] vs,
                         output int done_seen);
    xs = '0;
    vs = '0;
    done_seen = 0;
    for (int i = 0; i < n; i++) begin
      xs = {xs[14:0], x};
      vs = {vs[14:0], x_valid};
      if (done) done_seen++;
      @(negedge clk);
    end
  endtask

  logic [15:0] xs;
  logic [15:0] vs;
  int          dn;
  int          cnt;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_x", x, IDLE_BIT);
    check("rst_x_valid", x_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    // T1: 0110 msb-first once
    begin_xfer(4'b0110, 1, 1'b1);
    collect(4, xs, vs, dn);
    check("t1_stream", xs[3:0], 4'b0110);
    check("t1_valid", vs[3:0], 4'b1111);
    check("t1_no_early_done", dn, 0);
    check("t1_done", done, 1);
    check("t1_busy_low", busy, 0);
    $display("T1 stream=%b", xs[3:0]);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    @(negedge clk);

    // T2: 0011 lsb-first twice
    begin_xfer(4'b0011, 2, 1'b0);
    collect(8 + GAP, xs, vs, dn);
    if (GAP != 0) begin
      check("t2_stream", xs[8:0], 9'b110001100);
      check("t2_valid", vs[8:0], 9'b111101111);
    end else begin
      check("t2_stream", xs[7:0], 8'b11001100);
      check("t2_valid", vs[7:0], 8'b11111111);
    end
    check("t2_done", done, 1);
    $display("T2 stream=%b", xs[8:0]);
    @(negedge clk);

    // T3: zero repeats
    begin_xfer(4'b1011, 0, 1'b1);
    check("t3_done", done, 1);
    check("t3_valid", x_valid, 0);
    check("t3_busy", busy, 0);
    @(negedge clk);
    check("t3_done_pulse", done, 0);
    $display("T3 zero-repeat done");
    @(negedge clk);

    // T4: abort mid-stream, then restart
    begin_xfer(4'b1010, 3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_valid", x_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    begin_xfer(4'b1001, 1, 1'b1);
    check("t4_restart_busy", busy, 1);
    check("t4_restart_x", x, 1);
    collect(4, xs, vs, dn);
    check("t4_restart_stream", xs[3:0], 4'b1001);
    check("t4_restart_done", done, 1);
    $display("T4 abort and restart stream=%b", xs[3:0]);
    @(negedge clk);

    // T5: input changes and start while busy are ignored
    begin_xfer(4'b0110, 2, 1'b1);
    xs = '0;
    for (int i = 0; i < 8 + GAP; i++) begin
      xs = {xs[14:0], x};
      if (i == 2) begin
        pattern    = 4'b1111;
        msb_first  = 1'b0;
        repeat_cnt = 8'd7;
        start      = 1'b1;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    if (GAP != 0) check("t5_stream", xs[8:0], 9'b011000110);
    else          check("t5_stream", xs[7:0], 8'b01100110);
    check("t5_done", done, 1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("t5_no_second", cnt, 0);
    $display("T5 stream=%b", xs[8:0]);

    // T6: asynchronous reset mid-shift
    begin_xfer(4'b1101, 5, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_x", x, IDLE_BIT);
    check("t6_valid", x_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    begin_xfer(4'b1000, 1, 1'b1);
    check("t6_restart_busy", busy, 1);
    check("t6_restart_x", x, 1);
    collect(4, xs, vs, dn);
    check("t6_done_after", done, 1);
    $display("T6 reset and restart stream=%b", xs[3:0]);
    @(negedge clk);

    // Maximum repeat count: done lands at offset PAT_W*R + GAP*(R-1)
    begin_xfer(4'b1001, 255, 1'b0);
    cnt = 0;
    while (!done && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("r255_len", cnt, PAT_W * 255 + GAP * 254);
    $display("R255 done after %0d cycles", cnt);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 24) == 0);
      pattern    = PAT_W'($urandom);
      msb_first  = 1'($urandom);
      repeat_cnt = ($urandom_range(0, 15) == 0) ? CNT_W'(20) : CNT_W'($urandom_range(0, 4));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (120) @(negedge clk);
    $display("Random phase complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
